crack_sequencer: RTL
====================

// Module: crack_sequencer
// PURPOSE
//  Top-level guess scheduler for the password cracker. It walks candidate passcodes over
//  [code_lo, code_hi] and hands each one to the layer-2 serial bit sender (tx_en/tx_code).
//  It counts the sender's per-bit completions, then waits for the guard's verdict.
//  It stops on the first accepted code (found) or after the last candidate (exhausted).
// PARAMETERS
//  WIDTH    16   passcode width in bits; the sender shifts exactly WIDTH bits per word
//  TIMEOUT  255  max cycles in WAIT_VERDICT before the attempt is scored as a fail (>=1)
// PORTS
//  clk            in   1        system clock, all logic on posedge
//  rst            in   1        synchronous active-high reset
//  start          in   1        begin a search; sampled only in IDLE, FOUND, EXHAUSTED
//  code_lo        in   WIDTH    first candidate; latched on accepted start
//  code_hi        in   WIDTH    last candidate (inclusive); latched on accepted start
//  guard_rd       in   1        guard ready to receive a passcode (same net the sender sees)
//  tx_bit_done    in   1        sender per-bit done level; each rising edge = one bit sent
//  verdict_valid  in   1        guard verdict strobe, qualifies verdict_ok
//  verdict_ok     in   1        1 = passcode accepted, 0 = rejected
//  tx_en          out  1        enable to the sender
//  tx_code        out  WIDTH    current candidate; stable for the whole attempt
//  busy           out  1        1 in any state except IDLE, FOUND, EXHAUSTED
//  found          out  1        sticky: code accepted
//  exhausted      out  1        sticky: range finished without acceptance
//  timeout_seen   out  1        sticky: at least one verdict timed out this search
//  found_code     out  WIDTH    accepted candidate, valid while found=1
//  attempts       out  WIDTH+1  candidates fully sent this search (saturates at all-ones)
// BEHAVIOUR
//  Reset: state=IDLE. Every output, the candidate register, the bit counter and the timer are 0.
//   Reset mid-search aborts immediately with no further tx_en.
//  All outputs are registered.
//  States: IDLE, WAIT_RD, SEND, WAIT_VERDICT, NEXT, FOUND, EXHAUSTED.
//  IDLE/FOUND/EXHAUSTED + start:
//   - Latch lo/hi into cand/hi_r. Clear found, exhausted, timeout_seen, attempts, found_code.
//   - If code_lo > code_hi: go to EXHAUSTED next cycle with attempts=0.
//   - Otherwise go to WAIT_RD.
//  start while busy=1 is ignored.
//  WAIT_RD: tx_en=0. When guard_rd=1, go to SEND and set tx_en=1 on the same edge.
//  SEND:
//   - Rising edges of tx_bit_done are detected against a registered copy (the level may
//     persist for several cycles).
//   - tx_en drops on the edge after the first rising edge and stays 0 for the rest of SEND,
//     so the sender cannot relaunch when it returns to idle.
//   - After WIDTH rising edges: attempts += 1, timer=0, go to WAIT_VERDICT.
//   - verdict_valid is ignored in SEND.
//  WAIT_VERDICT: timer increments every cycle.
//   - verdict_valid & verdict_ok: found_code=cand, found=1, go to FOUND.
//   - verdict_valid & !verdict_ok: go to NEXT.
//   - timer == TIMEOUT-1 with no verdict: timeout_seen=1, go to NEXT.
//   - verdict_valid in the same cycle as the timeout: the verdict wins and timeout_seen is unchanged.
//  NEXT (1 cycle):
//   - cand == hi_r: exhausted=1, go to EXHAUSTED. No wrap, even at hi_r = all-ones.
//   - Otherwise cand += 1, go to WAIT_RD.
//  Minimum cycles per attempt: 1 (WAIT_RD) + sender time + 1 (verdict) + 1 (NEXT).
//  tx_code changes only in NEXT and on an accepted start, never during SEND or WAIT_VERDICT.
//  found and exhausted are never 1 together. Both stay 0 while busy=1.
// TESTING
//  1 Reset: rst=1 for 2 cycles mid-SEND -> all outputs 0, state IDLE, no tx_en for 10 cycles.
//  2 Search: lo=0x0010, hi=0x0013, guard model accepts 0x0012 ->
//    tx_code goes 0x10, 0x11, 0x12; found=1, found_code=0x0012, attempts=3, busy=0.
//  3 Range miss: lo=hi=0x00FF, guard always rejects -> exactly 16 bit edges sent,
//    exhausted=1, attempts=1, found=0.
//  4 Timeout: TIMEOUT=4, no verdict ever, lo=0, hi=1 -> each attempt leaves WAIT_VERDICT
//    after 4 cycles; timeout_seen=1, exhausted=1, attempts=2.
//  5 Edges: tx_bit_done held high 3 cycles per bit -> counted once per bit.
//    lo=0xFFFF, hi=0xFFFF, reject -> exhausted, no wrap to 0x0000.
//  6 Inverted range: lo=5, hi=3, start -> exhausted=1 within 2 cycles, attempts=0, tx_en never high.
//    start pulsed while busy -> ignored, bounds unchanged.

Source files
------------

// File: rtl/crack_sequencer_if.sv
// Handshake and status bundle between the guess scheduler and its environment
// (start/range control, serial sender, guard verdict).
interface crack_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] code_lo;
  logic [WIDTH-1:0] code_hi;
  logic             guard_rd;
  logic             tx_bit_done;
  logic             verdict_valid;
  logic             verdict_ok;
  logic             tx_en;
  logic [WIDTH-1:0] tx_code;
  logic             busy;
  logic             found;
  logic             exhausted;
  logic             timeout_seen;
  logic [WIDTH-1:0] found_code;
  logic [WIDTH:0]   attempts;

  modport master (
    output start, code_lo, code_hi, guard_rd, tx_bit_done, verdict_valid, verdict_ok,
    input  tx_en, tx_code, busy, found, exhausted, timeout_seen, found_code, attempts
  );

  modport slave (
    input  start, code_lo, code_hi, guard_rd, tx_bit_done, verdict_valid, verdict_ok,
    output tx_en, tx_code, busy, found, exhausted, timeout_seen, found_code, attempts
  );
endinterface

// File: rtl/crack_sequencer.sv
// Guess scheduler: walks candidates over [code_lo, code_hi], hands each to the serial
// sender, counts its bit completions, then waits for the guard verdict or a timeout.
module crack_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  crack_sequencer_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);
  localparam logic [TW-1:0]    LAST_TMR = TW'(TIMEOUT - 1);
  localparam logic [WIDTH:0]   ATT_MAX  = {(WIDTH + 1){1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WAIT_RD      = 3'd1,
    ST_SEND         = 3'd2,
    ST_WAIT_VERDICT = 3'd3,
    ST_NEXT         = 3'd4,
    ST_FOUND        = 3'd5,
    ST_EXHAUSTED    = 3'd6
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] cand_r, cand_s;
  logic [WIDTH-1:0] hi_r, hi_s;
  logic [CW-1:0]    bit_cnt_r, bit_cnt_s;
  logic [TW-1:0]    timer_r, timer_s;
  logic             done_d_r;
  logic             tx_en_r, tx_en_s;
  logic             busy_r, busy_s;
  logic             found_r, found_s;
  logic             exhausted_r, exhausted_s;
  logic             timeout_seen_r, timeout_seen_s;
  logic [WIDTH-1:0] found_code_r, found_code_s;
  logic [WIDTH:0]   attempts_r, attempts_s;
  logic             rise_s;

  // The done level may stay high for several cycles; only its rising edge marks a bit.
  assign rise_s = bus.tx_bit_done & ~done_d_r;
  assign busy_s = (state_s != ST_IDLE) && (state_s != ST_FOUND) && (state_s != ST_EXHAUSTED);

  // Next-state and next-output logic for the search sequencer.
  always_comb begin
    state_s        = state_r;
    cand_s         = cand_r;
    hi_s           = hi_r;
    bit_cnt_s      = bit_cnt_r;
    timer_s        = timer_r;
    tx_en_s        = tx_en_r;
    found_s        = found_r;
    exhausted_s    = exhausted_r;
    timeout_seen_s = timeout_seen_r;
    found_code_s   = found_code_r;
    attempts_s     = attempts_r;
    case (state_r)
      ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
        tx_en_s = 1'b0;
        if (bus.start) begin
          cand_s         = bus.code_lo;
          hi_s           = bus.code_hi;
          found_s        = 1'b0;
          exhausted_s    = 1'b0;
          timeout_seen_s = 1'b0;
          found_code_s   = {WIDTH{1'b0}};
          attempts_s     = {(WIDTH + 1){1'b0}};
          bit_cnt_s      = {CW{1'b0}};
          timer_s        = {TW{1'b0}};
          if (bus.code_lo > bus.code_hi) begin
            exhausted_s = 1'b1;
            state_s     = ST_EXHAUSTED;
          end else begin
            state_s = ST_WAIT_RD;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_WAIT_RD: begin
        tx_en_s = 1'b0;
        if (bus.guard_rd) begin
          tx_en_s   = 1'b1;
          bit_cnt_s = {CW{1'b0}};
          state_s   = ST_SEND;
        end else begin
          state_s = ST_WAIT_RD;
        end
      end
      ST_SEND: begin
        // Dropping tx_en at the first bit keeps the sender from relaunching on its own.
        if (rise_s) begin
          tx_en_s = 1'b0;
          if (bit_cnt_r == LAST_BIT) begin
            bit_cnt_s = {CW{1'b0}};
            timer_s   = {TW{1'b0}};
            state_s   = ST_WAIT_VERDICT;
            if (attempts_r != ATT_MAX) begin
              attempts_s = attempts_r + 1'b1;
            end else begin
              attempts_s = attempts_r;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + 1'b1;
          end
        end else begin
          bit_cnt_s = bit_cnt_r;
        end
      end
      ST_WAIT_VERDICT: begin
        timer_s = timer_r + 1'b1;
        if (bus.verdict_valid && bus.verdict_ok) begin
          found_code_s = cand_r;
          found_s      = 1'b1;
          state_s      = ST_FOUND;
        end else if (bus.verdict_valid) begin
          state_s = ST_NEXT;
        end else if (timer_r == LAST_TMR) begin
          timeout_seen_s = 1'b1;
          state_s        = ST_NEXT;
        end else begin
          state_s = ST_WAIT_VERDICT;
        end
      end
      ST_NEXT: begin
        if (cand_r == hi_r) begin
          exhausted_s = 1'b1;
          state_s     = ST_EXHAUSTED;
        end else begin
          cand_s  = cand_r + 1'b1;
          state_s = ST_WAIT_RD;
        end
      end
      default: begin
        tx_en_s = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything and aborts any attempt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      cand_r         <= {WIDTH{1'b0}};
      hi_r           <= {WIDTH{1'b0}};
      bit_cnt_r      <= {CW{1'b0}};
      timer_r        <= {TW{1'b0}};
      done_d_r       <= 1'b0;
      tx_en_r        <= 1'b0;
      busy_r         <= 1'b0;
      found_r        <= 1'b0;
      exhausted_r    <= 1'b0;
      timeout_seen_r <= 1'b0;
      found_code_r   <= {WIDTH{1'b0}};
      attempts_r     <= {(WIDTH + 1){1'b0}};
    end else begin
      state_r        <= state_s;
      cand_r         <= cand_s;
      hi_r           <= hi_s;
      bit_cnt_r      <= bit_cnt_s;
      timer_r        <= timer_s;
      done_d_r       <= bus.tx_bit_done;
      tx_en_r        <= tx_en_s;
      busy_r         <= busy_s;
      found_r        <= found_s;
      exhausted_r    <= exhausted_s;
      timeout_seen_r <= timeout_seen_s;
      found_code_r   <= found_code_s;
      attempts_r     <= attempts_s;
    end
  end

  assign bus.tx_en        = tx_en_r;
  assign bus.tx_code      = cand_r;
  assign bus.busy         = busy_r;
  assign bus.found        = found_r;
  assign bus.exhausted    = exhausted_r;
  assign bus.timeout_seen = timeout_seen_r;
  assign bus.found_code   = found_code_r;
  assign bus.attempts     = attempts_r;

endmodule
